// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel button debounce controller.
package debounce_pkg;

  typedef enum logic [1:0] {S_LOW, S_CHK_HI, S_HIGH, S_CHK_LO} db_state_t;

  localparam int DEF_CLK_HZ  = 50_000_000;
  localparam int DEF_TICK_HZ = 1000;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Valid for div >= 2, which the divider requires anyway.
  function automatic int cnt_width(input int div);
    return $clog2(div);
  endfunction

  localparam int PRESC_W = cnt_width(calc_div(DEF_CLK_HZ, DEF_TICK_HZ));

endpackage

// File: rtl/tick_prescaler.sv
// Shared time base: registered one-cycle tick every DIV clocks while enabled.
module tick_prescaler
  import debounce_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int              CNT_W = cnt_width(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (enable) begin
      tick_d = (cnt_q == LAST);
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/debounce_tick_ctrl.sv
// N-channel debounce: 2-flop synchronizers, one shared prescaler, and per-channel
// FSMs that accept a new level after STABLE_TICKS consecutive stable ticks.
module debounce_tick_ctrl
  import debounce_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int CLK_HZ       = 50_000_000,
  parameter int TICK_HZ      = 1000,
  parameter int STABLE_TICKS = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             tick
);

  localparam int               DIV       = calc_div(CLK_HZ, TICK_HZ);
  localparam int               CCNT_W    = $clog2(STABLE_TICKS + 1);
  localparam logic [CCNT_W-1:0] CCNT_LAST = CCNT_W'(STABLE_TICKS - 1);

  logic [N_BTN-1:0] meta_q, sync_q;
  logic             tick_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= btn_raw;
      sync_q <= meta_q;
    end
  end

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick_w)
  );

  assign tick = tick_w;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    db_state_t         state_q, state_d;
    logic [CCNT_W-1:0] ccnt_q, ccnt_d;
    logic              press_q, press_d, release_q, release_d;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q   <= S_LOW;
        ccnt_q    <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        ccnt_q    <= ccnt_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // A bounce back to the current level is checked before the tick, so it wins.
    always_comb begin
      state_d = state_q;
      ccnt_d  = ccnt_q;
      unique case (state_q)
        S_LOW: begin
          if (sync_q[i]) begin
            state_d = S_CHK_HI;
            ccnt_d  = '0;
          end
        end
        S_CHK_HI: begin
          if (!sync_q[i]) begin
            state_d = S_LOW;
          end else if (tick_w) begin
            if (ccnt_q == CCNT_LAST) begin
              state_d = S_HIGH;
              ccnt_d  = '0;
            end else begin
              ccnt_d = ccnt_q + CCNT_W'(1);
            end
          end
        end
        S_HIGH: begin
          if (!sync_q[i]) begin
            state_d = S_CHK_LO;
            ccnt_d  = '0;
          end
        end
        S_CHK_LO: begin
          if (sync_q[i]) begin
            state_d = S_HIGH;
          end else if (tick_w) begin
            if (ccnt_q == CCNT_LAST) begin
              state_d = S_LOW;
              ccnt_d  = '0;
            end else begin
              ccnt_d = ccnt_q + CCNT_W'(1);
            end
          end
        end
        default: state_d = S_LOW;
      endcase
    end

    always_comb begin
      press_d   = (state_q == S_CHK_HI) && (state_d == S_HIGH);
      release_d = (state_q == S_CHK_LO) && (state_d == S_LOW);
    end

    assign btn_level[i]   = (state_q == S_HIGH) || (state_q == S_CHK_LO);
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule

// File: tb/tb_debounce_tick_ctrl.sv
// Self-checking bench: directed scenarios plus random stimulus against a
// behavioural model of the debounce rules.
module tb_debounce_tick_ctrl;

  localparam int N   = 4;
  localparam int DIV = 10;
  localparam int ST  = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_press, btn_release;
  logic         tick;

  debounce_tick_ctrl #(
    .N_BTN        (N),
    .CLK_HZ       (100),
    .TICK_HZ      (10),
    .STABLE_TICKS (ST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .tick        (tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: raw delayed two clocks, tick every DIV enabled clocks,
  // and a channel flips after ST ticks of continuous disagreement.
  int           run_m;
  bit           tick_m;
  bit [N-1:0]   s1_m, s2_m, level_m, press_m, rel_m, pend_m;
  int           ticks_m [N];

  task automatic model_reset();
    run_m   = 0;
    tick_m  = 1'b0;
    s1_m    = '0;
    s2_m    = '0;
    level_m = '0;
    press_m = '0;
    rel_m   = '0;
    pend_m  = '0;
    for (int c = 0; c < N; c++) ticks_m[c] = 0;
  endtask

  task automatic model_edge();
    bit         t_old;
    bit [N-1:0] s_old;
    t_old   = tick_m;
    s_old   = s2_m;
    s2_m    = s1_m;
    s1_m    = btn_raw;
    press_m = '0;
    rel_m   = '0;
    for (int c = 0; c < N; c++) begin
      if (!pend_m[c]) begin
        if (s_old[c] != level_m[c]) begin
          pend_m[c]  = 1'b1;
          ticks_m[c] = 0;
        end
      end else if (s_old[c] == level_m[c]) begin
        pend_m[c] = 1'b0;
      end else if (t_old) begin
        ticks_m[c]++;
        if (ticks_m[c] == ST) begin
          level_m[c] = s_old[c];
          pend_m[c]  = 1'b0;
          if (s_old[c]) press_m[c] = 1'b1;
          else          rel_m[c]   = 1'b1;
        end
      end
    end
    if (!enable) begin
      run_m  = 0;
      tick_m = 1'b0;
    end else begin
      run_m++;
      tick_m = (run_m % DIV) == 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge();
    #1;
    check("tick",    tick,        tick_m);
    check("level",   btn_level,   level_m);
    check("press",   btn_press,   press_m);
    check("release", btn_release, rel_m);
    check("press_release_excl", btn_press & btn_release, '0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("rst_level",   btn_level,   '0);
    check("rst_press",   btn_press,   '0);
    check("rst_release", btn_release, '0);
    check("rst_tick",    tick,        '0);
    model_reset();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int first_tick, second_tick, lat, cnt, rise;
    bit seen;

    model_reset();
    #1;
    check("por_level", btn_level, '0);
    check("por_press", btn_press, '0);
    step();
    step();
    reset = 1'b0;

    // Tick phase after reset release
    first_tick = 0;
    second_tick = 0;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (tick) begin
        if (first_tick == 0) first_tick = c;
        else if (second_tick == 0) second_tick = c;
      end
    end
    check("first_tick_cycle",  first_tick,  10);
    check("second_tick_cycle", second_tick, 20);

    // Clean press on channel 0
    btn_raw[0] = 1'b1;
    lat = 0;
    cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (btn_level[0] && lat == 0) lat = c;
      cnt += int'(btn_press[0]);
    end
    check("press_latency_window", (lat >= 23 && lat <= 33), 1);
    check("press_strobe_count", cnt, 1);
    check("others_low", btn_level[3:1], '0);

    // Bounce on channel 1, then settle high
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (i % 7 == 0) btn_raw[1] = ~btn_raw[1];
      step();
      cnt += int'(btn_press[1]) + int'(btn_release[1]);
    end
    check("bounce_no_strobe", cnt, 0);
    btn_raw[1] = 1'b1;
    cnt = 0;
    for (int c = 0; c < 45; c++) begin
      step();
      cnt += int'(btn_press[1]);
    end
    check("bounce_settled_press", cnt, 1);

    // Release on channel 0
    btn_raw[0] = 1'b0;
    lat = 0;
    cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (!btn_level[0] && lat == 0) lat = c;
      cnt += int'(btn_release[0]);
    end
    check("release_latency_window", (lat >= 23 && lat <= 33), 1);
    check("release_strobe_count", cnt, 1);

    // Enable gating on channel 2
    enable = 1'b0;
    btn_raw[2] = 1'b1;
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      cnt += int'(tick);
    end
    check("gated_tick_count", cnt, 0);
    check("gated_level2", btn_level[2], 1'b0);
    enable = 1'b1;
    rise = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (btn_level[2] && rise == 0) rise = c;
    end
    check("reenable_rise_window", (rise > 0 && rise <= 33), 1);

    // Simultaneous press on all channels
    btn_raw = '0;
    for (int c = 0; c < 50; c++) step();
    check("all_low_before_simul", btn_level, '0);
    btn_raw = '1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (btn_press != '0 && !seen) begin
        seen = 1'b1;
        check("simul_press", btn_press, 4'hF);
      end
    end
    check("simul_press_seen", seen, 1'b1);

    // Reset in the middle of a release window
    btn_raw[0] = 1'b0;
    for (int c = 0; c < 15; c++) step();
    apply_reset();
    for (int c = 0; c < 40; c++) step();
    check("post_reset_levels", btn_level, 4'hE);

    // Randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 29) == 0) btn_raw[c] = ~btn_raw[c];
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      if (i == 1200) apply_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
